// File: rtl/decode_cycle_pkg.sv
// Shared decode constants, control bundle and ID/EX bundle types.
// Also holds the funct3-driven ALU operation lookup used by the decoder.
package decode_cycle_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_control;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } id_ex_t;

  // Returns {legal, alu_code}; sub selects subtract for funct3 000.
  function automatic logic [3:0] alu_decode(
    input logic [2:0] f3,
    input logic       sub
  );
    case (f3)
      3'b000:  return {1'b1, sub ? ALU_SUB : ALU_ADD};
      3'b010:  return {1'b1, ALU_SLT};
      3'b110:  return {1'b1, ALU_OR};
      3'b111:  return {1'b1, ALU_AND};
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/decode_cycle_register_file.sv
// 32x32 register file: two async reads, one sync write, x0 hardwired.
// Reads see a same-cycle write to the same register.
module register_file
  import decode_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] mem [32];
  logic        wr_ok;

  assign wr_ok = we && (wa != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (wr_ok && wa == ra1) rd1 = wd;
    if (wr_ok && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: control/immediate decode, register read, ID/EX register.
// Flush and reset both load a bubble into the ID/EX register.
module decode_cycle
  import decode_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  RDE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  logic [6:0]  op;
  logic [3:0]  alu;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm;
  imm_t        imm_sel;
  ctrl_t       ctrl;
  id_ex_t      id_ex;

  assign op  = InstrD[6:0];
  assign alu = alu_decode(InstrD[14:12],
                          (op == OP_R) && InstrD[30]);

  register_file u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (InstrD[19:15]),
    .ra2 (InstrD[24:20]),
    .we  (RegWriteW),
    .wa  (RDW),
    .wd  (ResultW),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always_comb begin
    ctrl    = '0;
    imm_sel = IMM_NONE;
    unique case (1'b1)
      op == OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        imm_sel         = IMM_I;
      end
      op == OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_sel        = IMM_S;
      end
      op == OP_R: begin
        ctrl.reg_write   = alu[3];
        ctrl.alu_control = alu[2:0];
      end
      op == OP_I: begin
        ctrl.reg_write   = alu[3];
        ctrl.alu_src     = alu[3];
        ctrl.alu_control = alu[2:0];
        imm_sel          = IMM_I;
      end
      op == OP_BEQ: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        imm_sel          = IMM_B;
      end
      op == OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_sel         = IMM_J;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (imm_sel)
      IMM_I: imm = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S: imm = {{20{InstrD[31]}}, InstrD[31:25],
                    InstrD[11:7]};
      IMM_B: imm = {{20{InstrD[31]}}, InstrD[7],
                    InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J: imm = {{12{InstrD[31]}}, InstrD[19:12],
                    InstrD[20], InstrD[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || FlushE) begin
      id_ex <= '0;
    end else begin
      id_ex <= '{ctrl:     ctrl,
                 rd1:      rd1,
                 rd2:      rd2,
                 imm:      imm,
                 rd:       InstrD[11:7],
                 pc:       PCD,
                 pc_plus4: PCPlus4D};
    end
  end

  assign RegWriteE   = id_ex.ctrl.reg_write;
  assign ResultSrcE  = id_ex.ctrl.result_src;
  assign MemWriteE   = id_ex.ctrl.mem_write;
  assign JumpE       = id_ex.ctrl.jump;
  assign BranchE     = id_ex.ctrl.branch;
  assign ALUSrcE     = id_ex.ctrl.alu_src;
  assign ALUControlE = id_ex.ctrl.alu_control;
  assign RD1E        = id_ex.rd1;
  assign RD2E        = id_ex.rd2;
  assign ImmExtE     = id_ex.imm;
  assign RDE         = id_ex.rd;
  assign PCE         = id_ex.pc;
  assign PCPlus4E    = id_ex.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Randomized bench for decode_cycle against an instruction-level model.
// Directed scenarios first, then random traffic with flushes and resets.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] InstrD = '0;
  logic [31:0] PCD = '0;
  logic [31:0] PCPlus4D = '0;
  logic        RegWriteW = 1'b0;
  logic [4:0]  RDW = '0;
  logic [31:0] ResultW = '0;
  logic        FlushE = 1'b0;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [4:0]  RDE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mregs [32];

  logic        e_rw, e_mw, e_j, e_b, e_as;
  logic [1:0]  e_rs;
  logic [2:0]  e_ac;
  logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pc4;
  logic [4:0]  e_rd;

  decode_cycle dut (
    .clk         (clk),
    .rst         (rst),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .RegWriteW   (RegWriteW),
    .RDW         (RDW),
    .ResultW     (ResultW),
    .FlushE      (FlushE),
    .RegWriteE   (RegWriteE),
    .ResultSrcE  (ResultSrcE),
    .MemWriteE   (MemWriteE),
    .JumpE       (JumpE),
    .BranchE     (BranchE),
    .ALUSrcE     (ALUSrcE),
    .ALUControlE (ALUControlE),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .ImmExtE     (ImmExtE),
    .RDE         (RDE),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_exp();
    {e_rw, e_mw, e_j, e_b, e_as} = '0;
    e_rs  = '0;
    e_ac  = '0;
    e_rd1 = '0;
    e_rd2 = '0;
    e_imm = '0;
    e_pc  = '0;
    e_pc4 = '0;
    e_rd  = '0;
  endtask

  // Two's-complement value of an n-bit field, widened to 32 bits.
  function automatic logic [31:0] sx(input longint v, input int n);
    if (v >= (64'sd1 << (n - 1))) v = v - (64'sd1 << n);
    return 32'(v);
  endfunction

  task automatic ref_decode(input logic [31:0] ins);
    int f3;
    int alu;
    f3  = int'(ins[14:12]);
    alu = -1;
    if (f3 == 0) alu = (ins[6:0] == 7'h33 && ins[30]) ? 1 : 0;
    if (f3 == 2) alu = 5;
    if (f3 == 6) alu = 3;
    if (f3 == 7) alu = 2;
    case (ins[6:0])
      7'h03: begin
        e_rw = 1; e_as = 1; e_rs = 2'd1;
        e_imm = sx(longint'(ins[31:20]), 12);
      end
      7'h23: begin
        e_mw = 1; e_as = 1;
        e_imm = sx(longint'({ins[31:25], ins[11:7]}), 12);
      end
      7'h33: begin
        if (alu >= 0) begin
          e_rw = 1; e_ac = 3'(alu);
        end
      end
      7'h13: begin
        if (alu >= 0) begin
          e_rw = 1; e_as = 1; e_ac = 3'(alu);
        end
        e_imm = sx(longint'(ins[31:20]), 12);
      end
      7'h63: begin
        e_b = 1; e_ac = 3'd1;
        e_imm = sx(longint'({ins[31], ins[7], ins[30:25],
                             ins[11:8]}) * 2, 13);
      end
      7'h6F: begin
        e_rw = 1; e_j = 1; e_rs = 2'd2;
        e_imm = sx(longint'({ins[31], ins[19:12], ins[20],
                             ins[30:21]}) * 2, 21);
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] rd_model(input logic [4:0] a,
                                           input logic we,
                                           input logic [4:0] wa,
                                           input logic [31:0] wd);
    if (a == 0) return 0;
    if (we && wa == a) return wd;
    return mregs[a];
  endfunction

  task automatic cycle(input logic r, input logic [31:0] ins,
                       input logic f, input logic we,
                       input logic [4:0] wa,
                       input logic [31:0] wd);
    logic [31:0] pc;
    pc        = $urandom;
    rst       = r;
    InstrD    = ins;
    PCD       = pc;
    PCPlus4D  = pc + 32'd4;
    FlushE    = f;
    RegWriteW = we;
    RDW       = wa;
    ResultW   = wd;
    zero_exp();
    if (!r) begin
      for (int i = 0; i < 32; i++) mregs[i] = '0;
    end else begin
      if (!f) begin
        ref_decode(ins);
        e_rd1 = rd_model(ins[19:15], we, wa, wd);
        e_rd2 = rd_model(ins[24:20], we, wa, wd);
        e_rd  = ins[11:7];
        e_pc  = pc;
        e_pc4 = pc + 32'd4;
      end
      if (we && wa != 0) mregs[wa] = wd;
    end
    @(posedge clk);
    #1;
    check("RegWriteE",   32'(RegWriteE),   32'(e_rw));
    check("ResultSrcE",  32'(ResultSrcE),  32'(e_rs));
    check("MemWriteE",   32'(MemWriteE),   32'(e_mw));
    check("JumpE",       32'(JumpE),       32'(e_j));
    check("BranchE",     32'(BranchE),     32'(e_b));
    check("ALUSrcE",     32'(ALUSrcE),     32'(e_as));
    check("ALUControlE", 32'(ALUControlE), 32'(e_ac));
    check("RD1E",        RD1E,             e_rd1);
    check("RD2E",        RD2E,             e_rd2);
    check("ImmExtE",     ImmExtE,          e_imm);
    check("RDE",         32'(RDE),         32'(e_rd));
    check("PCE",         PCE,              e_pc);
    check("PCPlus4E",    PCPlus4E,         e_pc4);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  ops [7];
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00};
    ins = $urandom;
    ins[6:0] = ops[$urandom_range(0, 6)];
    if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
    if (ins[6:0] == 7'h33 && $urandom_range(0, 1) == 1)
      ins[29:25] = '0;
    return ins;
  endfunction

  initial begin
    cycle(0, 32'h006283B3, 0, 1, 5, 32'h77);
    cycle(0, 32'h006283B3, 1, 0, 0, 0);
    check("rst_regwrite", 32'(RegWriteE), 32'd0);
    check("rst_rd1", RD1E, 32'd0);

    cycle(1, 32'h0, 0, 1, 5, 32'hAA);
    cycle(1, 32'h0, 0, 1, 6, 32'h11);
    cycle(1, 32'h006283B3, 0, 0, 0, 0);
    check("add_rd1", RD1E, 32'hAA);
    check("add_rd2", RD2E, 32'h11);
    check("add_rde", 32'(RDE), 32'd7);
    check("add_rw", 32'(RegWriteE), 32'd1);

    cycle(1, 32'hFFC12083, 0, 0, 0, 0);
    check("lw_imm", ImmExtE, 32'hFFFFFFFC);
    check("lw_src", 32'(ResultSrcE), 32'd1);

    cycle(1, 32'h0, 0, 1, 0, 32'hDEAD);
    cycle(1, 32'h00000033, 0, 0, 0, 0);
    check("x0_read", RD1E, 32'd0);

    cycle(1, 32'h006283B3, 0, 1, 5, 32'h1234);
    check("bypass_rd1", RD1E, 32'h1234);

    cycle(1, 32'h006283B3, 1, 1, 6, 32'h55);
    check("flush_rw", 32'(RegWriteE), 32'd0);
    cycle(1, 32'h006283B3, 0, 0, 0, 0);
    check("flush_wr_seen", RD2E, 32'h55);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) != 0), rand_instr(),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) != 0),
            5'($urandom), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle
Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-003 InstrD  input  32  instruction from fetch-to-decode register.
REQ-004 PCD  input  32  PC of InstrD.
REQ-005 PCPlus4D  input  32  PCD+4.
REQ-006 RegWriteW  input  1  writeback enable.
REQ-007 RDW  input  5  writeback destination register.
REQ-008 ResultW  input  32  writeback data.
REQ-009 FlushE  input  1  insert bubble into decode-to-execute register (taken branch/jump).
REQ-010 RegWriteE  output  1  register write enable for execute.
REQ-011 ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4.
REQ-012 MemWriteE  output  1  store enable.
REQ-013 JumpE  output  1  jal.
REQ-014 BranchE  output  1  beq.
REQ-015 ALUSrcE  output  1  0 RD2E, 1 ImmExtE.
REQ-016 ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-017 RD1E, RD2E  output  32 each  rs1/rs2 read data.
REQ-018 ImmExtE  output  32  sign-extended immediate.
REQ-019 RDE  output  5  destination register (InstrD[11:7]).
REQ-020 PCE, PCPlus4E  output  32 each  PCD/PCPlus4D delayed one cycle.
Function
REQ-021 Decode SHALL be combinational from InstrD; all E outputs SHALL be registered, latency exactly one clk.
REQ-022 Opcodes: 0000011 lw (RegWrite, ALUSrc, ResultSrc 01, imm I); 0100011 sw (MemWrite, ALUSrc, imm S); 0110011 R-type (RegWrite); 0010011 I-ALU (RegWrite, ALUSrc, imm I); 1100011 beq (Branch, sub, imm B); 1101111 jal (RegWrite, Jump, ResultSrc 10, imm J).
REQ-023 ALUControl: lw/sw/jal add; beq sub; funct3 000 add, or sub when R-type and funct7[5]=1; 010 slt; 110 or; 111 and.
REQ-024 Unsupported opcode or funct3 SHALL yield all control outputs 0 (NOP); data fields still registered.
REQ-025 Immediates SHALL be sign-extended from InstrD[31]; B and J immediates SHALL have bit0=0.
REQ-026 Register file: 32x32; reads of x0 SHALL return 0; write on rising edge when RegWriteW=1 and RDW!=0; writes to x0 ignored.
REQ-027 Same-cycle write and read of same nonzero register SHALL return ResultW (write-through bypass).
REQ-028 FlushE=1 SHALL load all E outputs with 0 on next edge; register-file write in same cycle SHALL still occur.
REQ-029 rst=0 and FlushE=1 together: reset behaviour applies.
Reset
REQ-030 On rst=0 at an edge, all E outputs SHALL become 0 and all 32 registers SHALL clear to 0; writeback in that cycle SHALL be discarded.
REQ-031 Reset mid-stream SHALL discard the in-flight instruction; first post-reset output reflects InstrD sampled at first edge with rst=1.
Structure
REQ-032 Shared package SHALL hold opcode constants, ALUControl codes, ResultSrc codes, immediate-type codes.
REQ-033 One sub-module register_file (2 async read, 1 sync write, bypass, sync reset); decoder and ID/EX register inline.
Verification
REQ-034 rst=0 two cycles with InstrD=0x006283B3 -> all E outputs 0.
REQ-035 Write x5=0xAA, x6=0x11 via W port; InstrD=0x006283B3 (add x7,x5,x6) -> next cycle RD1E=0xAA, RD2E=0x11, RDE=7, RegWriteE=1, ALUControlE=000.
REQ-036 InstrD=0xFFC12083 (lw x1,-4(x2)) -> ImmExtE=0xFFFFFFFC, ALUSrcE=1, ResultSrcE=01, RDE=1.
REQ-037 RegWriteW=1, RDW=0, ResultW=0xDEAD; then read x0 -> RD1E=0.
REQ-038 RegWriteW=1, RDW=5, ResultW=0x1234 same cycle as InstrD reading x5 -> RD1E=0x1234.
REQ-039 FlushE=1 with InstrD=0x006283B3 -> next cycle all E outputs 0; a concurrent W-port write is visible on a later read.
